// File: rtl/pagerank_gather_accumulator.sv
// Gather-phase accumulator for one PageRank partition: per-lane range filtering
// into a stage-1 register, then a saturating per-node commit into the accumulators.

module pagerank_gather_lane #(
    parameter int ID_WIDTH       = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int IDX_W          = 2,
    parameter int NODES          = 4,
    parameter int PARTITION_BASE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  accept,
    input  logic [ID_WIDTH-1:0]   dest_id,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  hit,
    output logic                  drop,
    output logic [IDX_W-1:0]      idx_q,
    output logic [DATA_WIDTH-1:0] data_q
);
    logic [ID_WIDTH-1:0] offset;
    logic                in_range;

    // IDs below the base wrap to huge offsets and fail the same unsigned compare
    assign offset   = dest_id - ID_WIDTH'(PARTITION_BASE);
    assign in_range = offset < ID_WIDTH'(NODES);
    assign hit      = accept && in_range;
    assign drop     = accept && !in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            data_q <= '0;
        end else if (hit) begin
            idx_q  <= offset[IDX_W-1:0];
            data_q <= data;
        end
    end
endmodule

module pagerank_gather_accumulator #(
    parameter int LANES              = 2,
    parameter int NODES_IN_PARTITION = 4,
    parameter int DATA_WIDTH         = 64,
    parameter int ID_WIDTH           = 32,
    parameter int PARTITION_BASE     = 0
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     pagerank_enable,
    input  logic                                     next_iteration,
    input  logic [LANES-1:0]                         update_valid,
    input  logic [LANES*ID_WIDTH-1:0]                dest_id,
    input  logic [LANES*DATA_WIDTH-1:0]              page_rank_scatter,
    input  logic                                     scatter_operation_complete,
    output logic                                     update_ready,
    output logic [NODES_IN_PARTITION*DATA_WIDTH-1:0] pagerank_pre_damp,
    output logic                                     gather_operation_complete,
    output logic [15:0]                              out_of_range_count,
    output logic                                     saturated
);
    localparam int IDX_W = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int SUM_W = DATA_WIDTH + CNT_W;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [LANES-1:0]                                 hit, drop, s1_vld;
    logic [LANES-1:0][IDX_W-1:0]                      s1_idx;
    logic [LANES-1:0][DATA_WIDTH-1:0]                 s1_data;
    logic [NODES_IN_PARTITION-1:0][DATA_WIDTH-1:0]    acc, acc_next;
    logic [NODES_IN_PARTITION-1:0][SUM_W-1:0]         sum;
    logic [NODES_IN_PARTITION-1:0]                    clip;
    logic [CNT_W-1:0]                                 n_drop;
    logic [16:0]                                      oor_sum;
    logic [15:0]                                      oor_next;

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state; next_iteration overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pagerank_enable) state_next = ACCUM;
            ACCUM:   if (!pagerank_enable) state_next = IDLE;
                     else if (scatter_operation_complete) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (next_iteration) state_next = pagerank_enable ? ACCUM : IDLE;
    end

    // FSM: outputs
    always_comb begin
        update_ready              = (state == ACCUM) && !next_iteration;
        gather_operation_complete = (state == DONE);
    end

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            pagerank_gather_lane #(
                .ID_WIDTH      (ID_WIDTH),
                .DATA_WIDTH    (DATA_WIDTH),
                .IDX_W         (IDX_W),
                .NODES         (NODES_IN_PARTITION),
                .PARTITION_BASE(PARTITION_BASE)
            ) u_lane (
                .clock  (clock),
                .reset  (reset),
                .accept (update_valid[i] && update_ready),
                .dest_id(dest_id[i*ID_WIDTH +: ID_WIDTH]),
                .data   (page_rank_scatter[i*DATA_WIDTH +: DATA_WIDTH]),
                .hit    (hit[i]),
                .drop   (drop[i]),
                .idx_q  (s1_idx[i]),
                .data_q (s1_data[i])
            );
        end
    endgenerate

    // Stage 2 reads the live accumulator, so same-node hits in consecutive cycles chain
    always_comb begin
        sum      = '0;
        clip     = '0;
        acc_next = acc;
        for (int n = 0; n < NODES_IN_PARTITION; n++) begin
            sum[n] = SUM_W'(acc[n]);
            for (int l = 0; l < LANES; l++)
                if (s1_vld[l] && s1_idx[l] == IDX_W'(n))
                    sum[n] = sum[n] + SUM_W'(s1_data[l]);
            clip[n]     = |sum[n][SUM_W-1:DATA_WIDTH];
            acc_next[n] = clip[n] ? '1 : sum[n][DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        n_drop = '0;
        for (int l = 0; l < LANES; l++)
            n_drop = n_drop + CNT_W'(drop[l]);
        oor_sum  = 17'(out_of_range_count) + 17'(n_drop);
        oor_next = oor_sum[16] ? 16'hFFFF : oor_sum[15:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc                <= '0;
            s1_vld             <= '0;
            out_of_range_count <= '0;
            saturated          <= 1'b0;
        end else if (next_iteration) begin
            acc                <= '0;
            s1_vld             <= '0;
            out_of_range_count <= '0;
            saturated          <= 1'b0;
        end else begin
            acc                <= acc_next;
            s1_vld             <= hit;
            out_of_range_count <= oor_next;
            saturated          <= saturated | (|clip);
        end
    end

    assign pagerank_pre_damp = acc;
endmodule

// File: tb/tb_pagerank_gather_accumulator.sv
// Directed bench for the gather accumulator (8-bit data, base 4): stimulus pushes
// hand-computed expectations with a due cycle; a negedge monitor pops and compares.

module tb_pagerank_gather_accumulator;
    localparam int LANES = 2;
    localparam int NODES = 4;
    localparam int DW    = 8;
    localparam int IDW   = 32;
    localparam int BASE  = 4;

    localparam int K_NODE  = 0;
    localparam int K_VEC   = 1;
    localparam int K_GDONE = 2;
    localparam int K_READY = 3;
    localparam int K_OOR   = 4;
    localparam int K_SAT   = 5;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  pagerank_enable = 1'b0;
    logic                  next_iteration = 1'b0;
    logic [LANES-1:0]      update_valid = '0;
    logic [LANES*IDW-1:0]  dest_id = '0;
    logic [LANES*DW-1:0]   page_rank_scatter = '0;
    logic                  scatter_operation_complete = 1'b0;
    logic                  update_ready;
    logic [NODES*DW-1:0]   pagerank_pre_damp;
    logic                  gather_operation_complete;
    logic [15:0]           out_of_range_count;
    logic                  saturated;

    typedef struct {
        int          due;
        int          kind;
        int          node;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    pagerank_gather_accumulator #(
        .LANES(LANES), .NODES_IN_PARTITION(NODES), .DATA_WIDTH(DW),
        .ID_WIDTH(IDW), .PARTITION_BASE(BASE)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .pagerank_enable           (pagerank_enable),
        .next_iteration            (next_iteration),
        .update_valid              (update_valid),
        .dest_id                   (dest_id),
        .page_rank_scatter         (page_rank_scatter),
        .scatter_operation_complete(scatter_operation_complete),
        .update_ready              (update_ready),
        .pagerank_pre_damp         (pagerank_pre_damp),
        .gather_operation_complete (gather_operation_complete),
        .out_of_range_count        (out_of_range_count),
        .saturated                 (saturated)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int kind, input int node);
        case (kind)
            K_NODE:  return 32'(pagerank_pre_damp[node*DW +: DW]);
            K_VEC:   return 32'(pagerank_pre_damp);
            K_GDONE: return 32'(gather_operation_complete);
            K_READY: return 32'(update_ready);
            K_OOR:   return 32'(out_of_range_count);
            default: return 32'(saturated);
        endcase
    endfunction

    // Monitor: compare every expectation that has come due at this sample point
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check(mon_e.name, observe(mon_e.kind, mon_e.node), mon_e.exp);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic sb_push(input int off, input int kind, input int node, input int val, input string name);
        sb.push_back('{due: cyc + off, kind: kind, node: node, exp: 32'(val), name: name});
    endtask

    task automatic lanes(input logic v0, input int d0, input int x0,
                         input logic v1, input int d1, input int x1);
        update_valid      = {v1, v0};
        dest_id           = {32'(d1), 32'(d0)};
        page_rank_scatter = {8'(x1), 8'(x0)};
    endtask

    task automatic drain_sb;
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick;
        if (sb.size() > 0) begin
            $display("FAIL drain_timeout: %0d expectations still pending, required 0", sb.size());
            n_vec  += sb.size();
            n_miss += sb.size();
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes(0, 0, 0, 0, 0, 0);
        tick; tick;
        sb_push(0, K_VEC,   0, 0, "rst_pre_damp");
        sb_push(0, K_GDONE, 0, 0, "rst_gdone");
        sb_push(0, K_READY, 0, 0, "rst_ready");
        sb_push(0, K_OOR,   0, 0, "rst_oor");
        sb_push(0, K_SAT,   0, 0, "rst_sat");
        tick;
        reset = 1'b0;
        pagerank_enable = 1'b1;
        sb_push(1, K_READY, 0, 1, "ready_accum");
        tick;

        // single-lane stream into local node 2: 4, 10x5, 3 -> 57
        lanes(1, 6, 4, 0, 0, 0);
        sb_push(2, K_NODE, 2, 4, "stream_first");
        for (int i = 1; i <= 10; i++) begin
            tick;
            lanes(1, 6, 5, 0, 0, 0);
            sb_push(2, K_NODE, 2, 4 + 5 * i, "stream_run");
        end
        tick;
        lanes(1, 6, 3, 0, 0, 0);
        scatter_operation_complete = 1'b1;
        sb_push(1, K_READY, 0, 0, "ready_drain");
        sb_push(1, K_GDONE, 0, 0, "gdone_drain");
        sb_push(2, K_NODE,  2, 57, "stream_total");
        sb_push(2, K_GDONE, 0, 1, "gdone_rise");
        sb_push(2, K_NODE,  0, 0, "stream_node0");
        sb_push(2, K_NODE,  1, 0, "stream_node1");
        sb_push(2, K_NODE,  3, 0, "stream_node3");
        tick;
        lanes(0, 0, 0, 0, 0, 0);
        scatter_operation_complete = 1'b0;
        tick; tick;
        sb_push(0, K_GDONE, 0, 1, "gdone_hold");
        sb_push(0, K_READY, 0, 0, "ready_done");

        // restart, then same-cycle and cross-cycle collisions
        next_iteration = 1'b1;
        sb_push(1, K_NODE,  2, 0, "ni_clear");
        sb_push(1, K_GDONE, 0, 0, "ni_gdone");
        tick;
        next_iteration = 1'b0;
        sb_push(0, K_READY, 0, 1, "ni_ready");
        lanes(1, 5, 5, 1, 5, 7);
        sb_push(2, K_NODE, 1, 12, "coll_same");
        tick;
        lanes(1, 5, 1, 1, 7, 3);
        sb_push(2, K_NODE, 1, 13, "coll_next");
        sb_push(2, K_NODE, 3, 3, "lane1_node3");
        tick;
        lanes(1, 4, 2, 1, 4, 6);
        sb_push(2, K_NODE, 0, 8, "coll_node0");
        tick;
        lanes(0, 0, 0, 0, 0, 0);
        tick;

        // range filter: dest 3 (below base) and 8 dropped, dest 5 -> local 1
        next_iteration = 1'b1;
        tick;
        next_iteration = 1'b0;
        sb_push(0, K_VEC, 0, 0, "ni_vec");
        lanes(1, 3, 1, 1, 8, 1);
        sb_push(1, K_OOR, 0, 2, "oor_two");
        tick;
        lanes(1, 5, 9, 0, 0, 0);
        sb_push(2, K_NODE, 1, 9, "range_node1");
        sb_push(2, K_VEC,  0, 32'h0000_0900, "range_vec");
        sb_push(2, K_OOR,  0, 2, "oor_hold");
        tick;
        lanes(0, 0, 0, 0, 0, 0);
        tick;

        // saturation across cycles and across lanes, then restart discards stage 1
        next_iteration = 1'b1;
        tick;
        next_iteration = 1'b0;
        sb_push(0, K_OOR, 0, 0, "ni_oor");
        lanes(1, 4, 200, 0, 0, 0);
        sb_push(2, K_NODE, 0, 200, "sat_first");
        sb_push(2, K_SAT,  0, 0, "sat_clear");
        tick;
        lanes(1, 4, 100, 0, 0, 0);
        sb_push(2, K_NODE, 0, 255, "sat_clip");
        sb_push(2, K_SAT,  0, 1, "sat_flag");
        tick;
        lanes(1, 7, 200, 1, 7, 200);
        sb_push(2, K_NODE, 3, 255, "sat_lanes");
        tick;
        lanes(1, 6, 9, 0, 0, 0);
        tick;
        lanes(0, 0, 0, 0, 0, 0);
        next_iteration = 1'b1;
        sb_push(0, K_READY, 0, 0, "ready_ni");
        sb_push(1, K_VEC,   0, 0, "ni_discard");
        sb_push(1, K_SAT,   0, 0, "ni_sat");
        tick;
        next_iteration = 1'b0;
        sb_push(0, K_READY, 0, 1, "ni_accum");

        // disable with an update in flight; later updates ignored
        lanes(1, 6, 7, 0, 0, 0);
        tick;
        lanes(0, 0, 0, 0, 0, 0);
        pagerank_enable = 1'b0;
        sb_push(1, K_NODE,  2, 7, "inflight_commit");
        sb_push(1, K_READY, 0, 0, "ready_idle");
        tick;
        lanes(1, 6, 50, 0, 0, 0);
        tick; tick;
        sb_push(0, K_NODE, 2, 7, "idle_ignored");
        lanes(0, 0, 0, 0, 0, 0);
        pagerank_enable = 1'b1;
        tick;

        // reach DONE with nonzero state, then async reset between edges
        lanes(1, 6, 250, 1, 100, 1);
        scatter_operation_complete = 1'b1;
        sb_push(1, K_OOR,   0, 1, "oor_one");
        sb_push(2, K_NODE,  2, 255, "done_node2");
        sb_push(2, K_SAT,   0, 1, "done_sat");
        sb_push(2, K_GDONE, 0, 1, "done_gdone");
        tick;
        lanes(0, 0, 0, 0, 0, 0);
        scatter_operation_complete = 1'b0;
        drain_sb;

        #1;
        reset = 1'b1;
        #1;
        check("arst_pre_damp", 32'(pagerank_pre_damp), 0);
        check("arst_gdone", 32'(gather_operation_complete), 0);
        check("arst_oor", 32'(out_of_range_count), 0);
        check("arst_sat", 32'(saturated), 0);
        check("arst_ready", 32'(update_ready), 0);
        #20;
        reset = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
